wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Receiving end of the execute-stage result interface: accepts ALU results (rd_data, destination, instruction type) from the execute stage over a valid/ready handshake.
- Buffers results in a 2-entry skid buffer.
- Drives the register-file write port, and exposes the youngest in-flight result for operand forwarding back to decode.
- Sits between the execute stage and the register file; decouples execute from register-file/commit stalls.

Parameters:
- XLEN, 64, data width (matches `REG_BUS).
- RADDR_W, 5, register address width.
- ITYPE_W, 5, instruction-type tag width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ex_valid_i  in  1  execute result valid
- ex_ready_o  out  1  wb_stage can accept a result
- ex_rd_wen_i  in  1  result writes a register
- ex_rd_addr_i  in  RADDR_W  destination register
- ex_rd_data_i  in  XLEN  result data
- ex_inst_type_i  in  ITYPE_W  instruction-type tag
- flush_i  in  1  discard all buffered results
- rf_ready_i  in  1  register file / commit accepts the head entry this cycle
- rf_wen_o  out  1  register-file write enable
- rf_waddr_o  out  RADDR_W  register-file write address
- rf_wdata_o  out  XLEN  register-file write data
- retire_o  out  1  head entry leaves this cycle
- retire_type_o  out  ITYPE_W  tag of the retiring entry
- fwd_valid_o  out  1  forwarding data valid
- fwd_addr_o  out  RADDR_W  forwarding destination
- fwd_data_o  out  XLEN  forwarding data

Behaviour:
- Storage: HEAD entry and SKID entry; each holds {wen, addr, data, type}.
- FSM states: EMPTY, ONE (HEAD valid), FULL (HEAD and SKID valid). Reset -> EMPTY, all entry fields 0.
- Handshakes:
  - acc = ex_valid_i & ex_ready_o & ~flush_i.
  - drn = (state != EMPTY) & rf_ready_i.
- ex_ready_o = (state != FULL); registered from the state, so it does not combinationally depend on rf_ready_i. Reset value 1 after the first clock in reset.
- Transitions:
  - EMPTY: acc -> ONE (load HEAD).
  - ONE:
    - acc & ~drn -> FULL (load SKID).
    - acc & drn -> ONE (HEAD <= incoming).
    - ~acc & drn -> EMPTY.
    - otherwise hold.
  - FULL (acc impossible):
    - drn -> ONE (HEAD <= SKID).
    - otherwise hold.
- flush_i has priority over all transitions: next state EMPTY, entries invalidated, incoming result dropped. The head entry is not written that cycle.
- Latency: a result accepted in cycle N appears on rf_* in cycle N+1 when EMPTY (1-cycle latency). Order is strictly FIFO.
- Register-file outputs:
  - rf_wen_o = HEAD valid & HEAD.wen & (HEAD.addr != 0) & rf_ready_i & ~flush_i.
  - Writes to x0 are suppressed but still retire.
  - rf_waddr_o / rf_wdata_o = HEAD fields, or 0 when EMPTY.
- retire_o = drn & ~flush_i; retire_type_o = HEAD.type.
- Forwarding:
  - Source is the youngest valid entry: SKID if FULL, else HEAD.
  - fwd_valid_o = source valid & source.wen & (source.addr != 0).
  - fwd_addr_o / fwd_data_o = source fields, 0 when not valid.
- Reset mid-operation: buffered entries are discarded with no rf write; all outputs are 0 except ex_ready_o = 1.
- No width conversion: data passes through unchanged.

Optional Feature:
- Macro WB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_retired_o (64) and perf_stall_o (64).
  - perf_retired_o increments on retire_o.
  - perf_stall_o increments on each cycle with state != EMPTY & ~rf_ready_i.
  - Both cleared by rst, not by flush_i, and wrap at 2^64.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- defines.v holds `REG_BUS, the instruction-type tag encodings (ITYPE_W values), and the FSM state encodings WB_EMPTY=2'd0, WB_ONE=2'd1, WB_FULL=2'd2.
- One sub-module is natural: wb_skid_buf, holding the generic 2-entry valid/ready skid buffer with flush. wb_stage wraps it and adds the x0 suppression, forwarding, and perf logic.

Test Plan:
- Single result: ex_valid_i=1, addr=5, data=0xDEAD_BEEF, wen=1, rf_ready_i=1 -> next cycle rf_wen_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF, retire_o=1; then EMPTY.
- Backpressure: rf_ready_i=0, send A(addr 1) and B(addr 2) on back-to-back cycles -> ex_ready_o=0 after B; fwd_addr_o=2. Raise rf_ready_i -> A then B written in order, and ex_ready_o returns to 1 once in ONE.
- x0 write: addr=0, wen=1, data=0x1234 -> retire_o=1, rf_wen_o=0, fwd_valid_o=0.
- Flush while FULL, with ex_valid_i=1 in the same cycle -> next state EMPTY, no rf_wen_o for any of the three results, ex_ready_o=1.
- Reset mid-stream: FULL, then rst=1 for 1 cycle -> all outputs 0 except ex_ready_o=1; entries lost.
- WB_PERF_CNT_EN: 10 retires with 3 stall cycles -> perf_retired_o=10, perf_stall_o=3; a flush leaves both unchanged.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: data-bus width, instruction-type tags
// and the skid-buffer state encoding.
package wb_stage_pkg;

  localparam int REG_BUS = 64;

  localparam logic [4:0] ITYPE_ALU    = 5'd0;
  localparam logic [4:0] ITYPE_LOAD   = 5'd1;
  localparam logic [4:0] ITYPE_STORE  = 5'd2;
  localparam logic [4:0] ITYPE_BRANCH = 5'd3;
  localparam logic [4:0] ITYPE_JUMP   = 5'd4;
  localparam logic [4:0] ITYPE_CSR    = 5'd5;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_ONE   = 2'd1,
    WB_FULL  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_stage_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush.
// HEAD is the oldest entry; the youngest entry (SKID when FULL, else HEAD) is exported.
module wb_stage_skid_buf
  import wb_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  input  logic         out_ready,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  output logic         young_valid,
  output logic [W-1:0] young_data
);

  wb_state_e    state_reg, state_next;
  logic [W-1:0] head_reg, head_next;
  logic [W-1:0] skid_reg, skid_next;
  logic         ready_reg;
  logic         acc, drn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= WB_EMPTY;
      head_reg  <= '0;
      skid_reg  <= '0;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      skid_reg  <= skid_next;
      ready_reg <= (state_next != WB_FULL);
    end
  end

  // Vacated entries are zeroed so the payload outputs read 0 when not valid.
  always_comb begin
    acc        = in_valid & ready_reg & ~flush;
    drn        = (state_reg != WB_EMPTY) & out_ready;
    state_next = state_reg;
    head_next  = head_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = WB_EMPTY;
      head_next  = '0;
      skid_next  = '0;
    end else begin
      case (state_reg)
        WB_EMPTY: begin
          if (acc) begin
            state_next = WB_ONE;
            head_next  = in_data;
          end
        end
        WB_ONE: begin
          if (acc && !drn) begin
            state_next = WB_FULL;
            skid_next  = in_data;
          end else if (acc && drn) begin
            head_next = in_data;
          end else if (drn) begin
            state_next = WB_EMPTY;
            head_next  = '0;
          end
        end
        WB_FULL: begin
          if (drn) begin
            state_next = WB_ONE;
            head_next  = skid_reg;
            skid_next  = '0;
          end
        end
        default: begin
          state_next = WB_EMPTY;
          head_next  = '0;
          skid_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready    = ready_reg;
    head_valid  = (state_reg != WB_EMPTY);
    head_data   = head_reg;
    young_valid = (state_reg != WB_EMPTY);
    young_data  = (state_reg == WB_FULL) ? skid_reg : head_reg;
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: buffers execute results, drives the register-file write port and
// forwarding. Optional performance counters are enabled with `define WB_PERF_CNT_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN    = REG_BUS,
  parameter int RADDR_W = 5,
  parameter int ITYPE_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid_i,
  output logic               ex_ready_o,
  input  logic               ex_rd_wen_i,
  input  logic [RADDR_W-1:0] ex_rd_addr_i,
  input  logic [XLEN-1:0]    ex_rd_data_i,
  input  logic [ITYPE_W-1:0] ex_inst_type_i,
  input  logic               flush_i,
  input  logic               rf_ready_i,
  output logic               rf_wen_o,
  output logic [RADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]    rf_wdata_o,
  output logic               retire_o,
  output logic [ITYPE_W-1:0] retire_type_o,
  output logic               fwd_valid_o,
  output logic [RADDR_W-1:0] fwd_addr_o,
  output logic [XLEN-1:0]    fwd_data_o
`ifdef WB_PERF_CNT_EN
  ,
  output logic [63:0]        perf_retired_o,
  output logic [63:0]        perf_stall_o
`endif
);

  localparam int EW = 1 + RADDR_W + XLEN + ITYPE_W;

  logic [EW-1:0]      in_entry, head_entry, young_entry;
  logic               head_valid, young_valid, drn;
  logic               head_wen, young_wen;
  logic [RADDR_W-1:0] head_addr, young_addr;
  logic [XLEN-1:0]    head_data, young_data;
  logic [ITYPE_W-1:0] head_type;
  logic               unused_young_type;

  assign in_entry = {ex_rd_wen_i, ex_rd_addr_i, ex_rd_data_i, ex_inst_type_i};

  wb_stage_skid_buf #(.W(EW)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (ex_valid_i),
    .in_ready    (ex_ready_o),
    .in_data     (in_entry),
    .flush       (flush_i),
    .out_ready   (rf_ready_i),
    .head_valid  (head_valid),
    .head_data   (head_entry),
    .young_valid (young_valid),
    .young_data  (young_entry)
  );

  assign {head_wen, head_addr, head_data, head_type} = head_entry;
  assign young_wen         = young_entry[EW-1];
  assign young_addr        = young_entry[EW-2 -: RADDR_W];
  assign young_data        = young_entry[ITYPE_W +: XLEN];
  assign unused_young_type = ^young_entry[ITYPE_W-1:0];

  // x0 results still retire; only the register-file write is suppressed.
  always_comb begin
    drn           = head_valid & rf_ready_i;
    retire_o      = drn & ~flush_i;
    rf_wen_o      = retire_o & head_wen & (head_addr != '0);
    rf_waddr_o    = head_valid ? head_addr : '0;
    rf_wdata_o    = head_valid ? head_data : '0;
    retire_type_o = head_valid ? head_type : '0;
    fwd_valid_o   = young_valid & young_wen & (young_addr != '0);
    fwd_addr_o    = fwd_valid_o ? young_addr : '0;
    fwd_data_o    = fwd_valid_o ? young_data : '0;
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (retire_o)
        perf_retired_o <= perf_retired_o + 64'd1;
      if (head_valid && !rf_ready_i)
        perf_stall_o <= perf_stall_o + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios then random traffic, all checked
// against a queue-based model of a 2-deep FIFO in front of the register file.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid_i = 1'b0, ex_rd_wen_i = 1'b0, flush_i = 1'b0, rf_ready_i = 1'b0;
  logic [4:0]  ex_rd_addr_i = '0, ex_inst_type_i = '0;
  logic [63:0] ex_rd_data_i = '0;
  logic        ex_ready_o, rf_wen_o, retire_o, fwd_valid_o;
  logic [4:0]  rf_waddr_o, retire_type_o, fwd_addr_o;
  logic [63:0] rf_wdata_o, fwd_data_o;
`ifdef WB_PERF_CNT_EN
  logic [63:0] perf_retired_o, perf_stall_o;
  longint unsigned m_retired, m_stall;
`endif

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [4:0]  typ;
  } ent_t;
  ent_t q[$];

  wb_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_rd_wen_i(ex_rd_wen_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_i(ex_rd_data_i), .ex_inst_type_i(ex_inst_type_i),
    .flush_i(flush_i), .rf_ready_i(rf_ready_i),
    .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .retire_o(retire_o), .retire_type_o(retire_type_o),
    .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o)
`ifdef WB_PERF_CNT_EN
    , .perf_retired_o(perf_retired_o), .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic v, input logic w, input logic [4:0] a, input logic [63:0] d,
                      input logic [4:0] t, input logic fl, input logic rr);
    ent_t h, y;
    logic exp_ready, exp_ret, exp_wen, exp_fv, acc;
    @(negedge clk);
    ex_valid_i = v; ex_rd_wen_i = w; ex_rd_addr_i = a; ex_rd_data_i = d;
    ex_inst_type_i = t; flush_i = fl; rf_ready_i = rr;
    #1;
    h = '{wen: 1'b0, addr: 5'd0, data: 64'd0, typ: 5'd0};
    y = h;
    if (q.size() > 0) begin
      h = q[0];
      y = q[q.size()-1];
    end
    exp_ready = (q.size() < 2);
    exp_ret   = (q.size() > 0) && rr && !fl;
    exp_wen   = exp_ret && h.wen && (h.addr != 5'd0);
    exp_fv    = (q.size() > 0) && y.wen && (y.addr != 5'd0);
    chk("ex_ready", 64'(ex_ready_o), 64'(exp_ready));
    chk("retire", 64'(retire_o), 64'(exp_ret));
    chk("rf_wen", 64'(rf_wen_o), 64'(exp_wen));
    chk("rf_waddr", 64'(rf_waddr_o), 64'(h.addr));
    chk("rf_wdata", rf_wdata_o, h.data);
    chk("retire_type", 64'(retire_type_o), 64'(h.typ));
    chk("fwd_valid", 64'(fwd_valid_o), 64'(exp_fv));
    chk("fwd_addr", 64'(fwd_addr_o), exp_fv ? 64'(y.addr) : 64'd0);
    chk("fwd_data", fwd_data_o, exp_fv ? y.data : 64'd0);
`ifdef WB_PERF_CNT_EN
    chk("perf_retired", perf_retired_o, m_retired);
    chk("perf_stall", perf_stall_o, m_stall);
    if (exp_ret) m_retired++;
    if (q.size() > 0 && !rr) m_stall++;
`endif
    acc = v && exp_ready && !fl;
    if (fl) q.delete();
    else begin
      if ((q.size() > 0) && rr) void'(q.pop_front());
      if (acc) q.push_back('{wen: w, addr: a, data: d, typ: t});
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ex_valid_i = 1'b1; rf_ready_i = 1'b1;
    @(negedge clk);
    rst = 1'b0; ex_valid_i = 1'b0;
    q.delete();
`ifdef WB_PERF_CNT_EN
    m_retired = 0; m_stall = 0;
`endif
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 1'b0, rr);
  endtask

  initial begin
    @(posedge clk); @(posedge clk);
    do_reset();
    #1 chk("reset_ready", 64'(ex_ready_o), 64'd1);
    idle(1'b1);

    // single result, 1-cycle latency
    step(1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF, 5'd0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // backpressure: A then B, then drain in order
    step(1'b1, 1'b1, 5'd1, 64'hAAAA, 5'd1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd2, 64'hBBBB, 5'd2, 1'b0, 1'b0);
    #1 chk("bp_ready_low", 64'(ex_ready_o), 64'd0);
    chk("bp_fwd_addr", 64'(fwd_addr_o), 64'd2);
    idle(1'b1);
    #1 chk("bp_ready_back", 64'(ex_ready_o), 64'd1);
    idle(1'b1);
    idle(1'b1);

    // write to x0
    step(1'b1, 1'b1, 5'd0, 64'h1234, 5'd3, 1'b0, 1'b1);
    idle(1'b1);

    // flush while FULL with a new result presented
    step(1'b1, 1'b1, 5'd7, 64'h77, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd8, 64'h88, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd9, 64'h99, 5'd0, 1'b1, 1'b1);
    idle(1'b1);

    // reset mid-stream while FULL
    step(1'b1, 1'b1, 5'd10, 64'hA0, 5'd1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd11, 64'hB0, 5'd2, 1'b0, 1'b0);
    do_reset();
    idle(1'b1);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
           5'($urandom_range(0, 31)), {$urandom, $urandom}, 5'($urandom_range(0, 5)),
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
